// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit control path.
package mdu_pkg;

    localparam int DATA_W = 32;
    localparam int RES_W  = 2 * DATA_W;

    // LSB offsets of the remainder (HI) and quotient (LO) fields in the divider result
    localparam int HI_SLICE = DATA_W;
    localparam int LO_SLICE = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/hilo_reg.sv
// Architectural HI/LO register pair with independent write enables.
module hilo_reg
    import mdu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hi_we_i,
    input  logic [DATA_W-1:0] hi_wd_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] lo_wd_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (hi_we_i) hi_q <= hi_wd_i;
            if (lo_we_i) lo_q <= lo_wd_i;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage divide issue/commit controller in front of div_self_align, owning HI/LO.
// Optional: define DIV_ZERO_BYPASS_EN to resolve divide-by-zero locally without the divider.
module div_issue_ctrl
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_div_req,
    input  logic              ex_div_sign,
    input  logic [DATA_W-1:0] ex_src_a,
    input  logic [DATA_W-1:0] ex_src_b,
    input  logic              ex_mthi,
    input  logic              ex_mtlo,
    input  logic [DATA_W-1:0] ex_mt_data,
    input  logic              flush,
    input  logic              stall_in,
    output logic              ex_stall,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] div_a,
    output logic [DATA_W-1:0] div_b,
    output logic              div_sign,
    output logic              div_opn_valid,
    output logic              div_rst,
    output logic              div_res_ready,
    input  logic              div_res_valid,
    input  logic [RES_W-1:0]  div_result
);

    div_state_t        state_q;
    logic [DATA_W-1:0] div_a_q;
    logic [DATA_W-1:0] div_b_q;
    logic              div_sign_q;
    logic              div_opn_valid_q;
    logic              div_res_ready_q;
    logic              div_rst_q;

    logic              accept;
    logic              bypass;
    logic              commit;
    logic              mt_ok;
    logic              hi_we_d;
    logic              lo_we_d;
    logic [DATA_W-1:0] hi_wd_d;
    logic [DATA_W-1:0] lo_wd_d;

    assign accept = (state_q == IDLE) & ex_div_req & ~flush;
`ifdef DIV_ZERO_BYPASS_EN
    assign bypass = accept & (ex_src_b == '0);
`else
    assign bypass = 1'b0;
`endif
    assign commit = (state_q == WAIT) & div_res_valid & ~flush;
    assign mt_ok  = (state_q == IDLE) & ~stall_in & ~flush;

    // commit and bypass live in different states; bypass outranks a stray MTHI/MTLO
    always_comb begin
        hi_we_d = 1'b0;
        lo_we_d = 1'b0;
        hi_wd_d = ex_mt_data;
        lo_wd_d = ex_mt_data;
        if (commit) begin
            hi_we_d = 1'b1;
            lo_we_d = 1'b1;
            hi_wd_d = div_result[HI_SLICE +: DATA_W];
            lo_wd_d = div_result[LO_SLICE +: DATA_W];
        end else if (bypass) begin
            hi_we_d = 1'b1;
            lo_we_d = 1'b1;
            hi_wd_d = ex_src_a;
            lo_wd_d = '1;
        end else if (mt_ok) begin
            hi_we_d = ex_mthi;
            lo_we_d = ex_mtlo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            div_a_q         <= '0;
            div_b_q         <= '0;
            div_sign_q      <= 1'b0;
            div_opn_valid_q <= 1'b0;
            div_res_ready_q <= 1'b0;
            div_rst_q       <= 1'b1;
        end else begin
            div_rst_q       <= flush;
            div_opn_valid_q <= 1'b0;
            div_res_ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (bypass) begin
                            state_q <= DONE;
                        end else begin
                            div_a_q         <= ex_src_a;
                            div_b_q         <= ex_src_b;
                            div_sign_q      <= ex_div_sign;
                            div_opn_valid_q <= 1'b1;
                            state_q         <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        state_q         <= WAIT;
                        div_res_ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else if (div_res_valid) begin
                        state_q <= DONE;
                    end else begin
                        div_res_ready_q <= 1'b1;
                    end
                end
                DONE: begin
                    // a still-held req here is the finished instruction, never a new one
                    if (flush | ~stall_in) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_stall = ((state_q == IDLE) & ex_div_req) | (state_q == ISSUE) | (state_q == WAIT);

    assign div_a         = div_a_q;
    assign div_b         = div_b_q;
    assign div_sign      = div_sign_q;
    assign div_opn_valid = div_opn_valid_q;
    assign div_res_ready = div_res_ready_q;
    assign div_rst       = div_rst_q;

    hilo_reg u_hilo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .hi_we_i (hi_we_d),
        .hi_wd_i (hi_wd_d),
        .lo_we_i (lo_we_d),
        .lo_wd_i (lo_wd_d),
        .hi_o    (hi),
        .lo_o    (lo)
    );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed bench for div_issue_ctrl; the bench itself plays the divider.
module tb_div_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        ex_div_req;
    logic        ex_div_sign;
    logic [31:0] ex_src_a;
    logic [31:0] ex_src_b;
    logic        ex_mthi;
    logic        ex_mtlo;
    logic [31:0] ex_mt_data;
    logic        flush;
    logic        stall_in;
    logic        ex_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_sign;
    logic        div_opn_valid;
    logic        div_rst;
    logic        div_res_ready;
    logic        div_res_valid;
    logic [63:0] div_result;

    int total = 0;
    int bad   = 0;

    div_issue_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .ex_div_req    (ex_div_req),
        .ex_div_sign   (ex_div_sign),
        .ex_src_a      (ex_src_a),
        .ex_src_b      (ex_src_b),
        .ex_mthi       (ex_mthi),
        .ex_mtlo       (ex_mtlo),
        .ex_mt_data    (ex_mt_data),
        .flush         (flush),
        .stall_in      (stall_in),
        .ex_stall      (ex_stall),
        .hi            (hi),
        .lo            (lo),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_sign      (div_sign),
        .div_opn_valid (div_opn_valid),
        .div_rst       (div_rst),
        .div_res_ready (div_res_ready),
        .div_res_valid (div_res_valid),
        .div_result    (div_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one divide from an IDLE cycle (caller is at posedge+1) and answers as the divider
    // 'iters' cycles after the launch pulse. Returns at the negedge of the first non-stall cycle.
    task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] res, input int iters,
                          output int oc, output int of, output int sc, output int ec,
                          output logic to);
        oc = 0; of = -1; sc = 0; ec = -1; to = 1'b1;
        ex_div_req = 1'b1; ex_div_sign = sg; ex_src_a = a; ex_src_b = b; div_result = res;
        for (int c = 0; c < 100; c++) begin
            div_res_valid = (of >= 0) && (c == of + iters);
            @(negedge clk);
            if (c > 0 && !ex_stall) begin
                ec = c;
                to = 1'b0;
                break;
            end
            if (ex_stall) sc++;
            if (div_opn_valid) begin
                oc++;
                if (of < 0) of = c;
            end
            @(posedge clk); #1;
        end
        div_res_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; ex_div_req = 0; ex_div_sign = 0; ex_src_a = 0; ex_src_b = 0;
        ex_mthi = 0; ex_mtlo = 0; ex_mt_data = 0; flush = 0; stall_in = 0;
        div_res_valid = 0; div_result = 0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'd0); end
        total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'd0); end
        total++; if (div_rst !== 1'b1) begin bad++; $display("FAIL reset_div_rst got=%b exp=1", div_rst); end
        total++; if ({ex_stall, div_opn_valid, div_res_ready, div_sign} !== 4'b0000) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000", {ex_stall, div_opn_valid, div_res_ready, div_sign});
        end
        total++; if ({div_a, div_b} !== 64'd0) begin bad++; $display("FAIL reset_opnd got=%h exp=0", {div_a, div_b}); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (div_rst !== 1'b1) begin bad++; $display("FAIL reset_div_rst_hold got=%b exp=1", div_rst); end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (div_rst !== 1'b0) begin bad++; $display("FAIL reset_div_rst_rel got=%b exp=0", div_rst); end
        @(posedge clk); #1;
    endtask

    task automatic test_div_basic();
        int oc, of, sc, ec;
        logic to;
        do_div(1'b1, 32'd100, 32'd7, {32'd2, 32'd14}, 4, oc, of, sc, ec, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL basic_timeout got=%b exp=0", to); end
        total++; if (oc !== 1) begin bad++; $display("FAIL basic_opn_count got=%0d exp=1", oc); end
        total++; if (of !== 1) begin bad++; $display("FAIL basic_opn_cycle got=%0d exp=1", of); end
        total++; if (sc !== 6) begin bad++; $display("FAIL basic_stall_cycles got=%0d exp=6", sc); end
        total++; if (ec !== 6) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=6", ec); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL basic_hi got=%h exp=%h", hi, 32'd2); end
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL basic_lo got=%h exp=%h", lo, 32'd14); end
        total++; if ({div_sign, div_a, div_b} !== {1'b1, 32'd100, 32'd7}) begin
            bad++; $display("FAIL basic_operands got=%b/%h/%h exp=1/%h/%h", div_sign, div_a, div_b, 32'd100, 32'd7);
        end
        total++; if (div_res_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%b exp=0", div_res_ready); end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    task automatic test_div_signs();
        int oc, of, sc, ec;
        logic to;
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 2, oc, of, sc, ec, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL neg_timeout got=%b exp=0", to); end
        total++; if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL neg_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
        total++; if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL neg_lo got=%h exp=%h", lo, 32'hFFFF_FFFD); end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(posedge clk); #1;
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 3, oc, of, sc, ec, to);
        total++; if (sc !== 5) begin bad++; $display("FAIL divu_stall_cycles got=%0d exp=5", sc); end
        total++; if (hi !== 32'd0) begin bad++; $display("FAIL divu_hi got=%h exp=%h", hi, 32'd0); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL divu_lo got=%h exp=%h", lo, 32'hFFFF_FFFF); end
        total++; if (div_sign !== 1'b0) begin bad++; $display("FAIL divu_sign got=%b exp=0", div_sign); end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    task automatic test_flush_wait();
        int oc, of, sc, ec;
        logic to;
        ex_div_req = 1'b1; ex_div_sign = 1'b1; ex_src_a = 32'd50; ex_src_b = 32'd5;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (div_opn_valid !== 1'b1) begin bad++; $display("FAIL flush_issue_opn got=%b exp=1", div_opn_valid); end
        @(posedge clk); #1;
        flush = 1'b1; ex_div_req = 1'b0;
        div_res_valid = 1'b1; div_result = 64'h1111_1111_2222_2222;
        @(negedge clk);
        total++; if (div_res_ready !== 1'b1) begin bad++; $display("FAIL flush_wait_ready got=%b exp=1", div_res_ready); end
        total++; if (div_rst !== 1'b0) begin bad++; $display("FAIL flush_rst_early got=%b exp=0", div_rst); end
        @(posedge clk); #1;
        flush = 1'b0; div_res_valid = 1'b0;
        @(negedge clk);
        total++; if (div_rst !== 1'b1) begin bad++; $display("FAIL flush_div_rst got=%b exp=1", div_rst); end
        total++; if ({ex_stall, div_res_ready} !== 2'b00) begin
            bad++; $display("FAIL flush_idle got=%b exp=00", {ex_stall, div_res_ready});
        end
        total++; if ({hi, lo} !== {32'd0, 32'hFFFF_FFFF}) begin
            bad++; $display("FAIL flush_hilo_kept got=%h exp=%h", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (div_rst !== 1'b0) begin bad++; $display("FAIL flush_div_rst_drop got=%b exp=0", div_rst); end
        @(posedge clk); #1;
        do_div(1'b1, 32'd9, 32'd3, {32'd0, 32'd3}, 2, oc, of, sc, ec, to);
        total++; if (oc !== 1) begin bad++; $display("FAIL flush_next_opn got=%0d exp=1", oc); end
        total++; if ({hi, lo} !== {32'd0, 32'd3}) begin
            bad++; $display("FAIL flush_next_hilo got=%h exp=%h", {hi, lo}, {32'd0, 32'd3});
        end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
    endtask

    task automatic test_done_hold();
        int oc, of, sc, ec;
        logic to;
        stall_in = 1'b1;
        do_div(1'b1, 32'd20, 32'd6, {32'd2, 32'd3}, 2, oc, of, sc, ec, to);
        total++; if ({hi, lo} !== {32'd2, 32'd3}) begin
            bad++; $display("FAIL hold_hilo got=%h exp=%h", {hi, lo}, {32'd2, 32'd3});
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            total++; if ({ex_stall, div_opn_valid} !== 2'b00) begin
                bad++; $display("FAIL hold_no_reissue got=%b exp=00 cyc=%0d", {ex_stall, div_opn_valid}, i);
            end
        end
        @(posedge clk); #1;
        stall_in = 1'b0; ex_div_req = 1'b0; ex_mthi = 1'b1; ex_mt_data = 32'hAAAA_5555;
        @(posedge clk); #1;
        @(negedge clk);
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL hold_mt_in_done got=%h exp=%h", hi, 32'd2); end
        @(posedge clk); #1;
        ex_mthi = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'hAAAA_5555) begin bad++; $display("FAIL hold_back_idle got=%h exp=%h", hi, 32'hAAAA_5555); end
        @(posedge clk); #1;
    endtask

    task automatic test_mt();
        ex_mthi = 1'b1; ex_mt_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        ex_mthi = 1'b0; ex_mtlo = 1'b1; ex_mt_data = 32'h1234_5678;
        @(posedge clk); #1;
        ex_mtlo = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mt_hi got=%h exp=%h", hi, 32'hDEAD_BEEF); end
        total++; if (lo !== 32'h1234_5678) begin bad++; $display("FAIL mt_lo got=%h exp=%h", lo, 32'h1234_5678); end
        @(posedge clk); #1;
        stall_in = 1'b1; ex_mthi = 1'b1; ex_mt_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        stall_in = 1'b0; ex_mthi = 1'b0;
        @(negedge clk);
        total++; if (hi !== 32'hDEAD_BEEF) begin bad++; $display("FAIL mt_stalled got=%h exp=%h", hi, 32'hDEAD_BEEF); end
        @(posedge clk); #1;
        flush = 1'b1; ex_mtlo = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; ex_mtlo = 1'b0;
        @(negedge clk);
        total++; if (lo !== 32'h1234_5678) begin bad++; $display("FAIL mt_flushed got=%h exp=%h", lo, 32'h1234_5678); end
        @(posedge clk); #1;
        ex_mthi = 1'b1; ex_mtlo = 1'b1; ex_mt_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        ex_mthi = 1'b0; ex_mtlo = 1'b0;
        @(negedge clk);
        total++; if ({hi, lo} !== {32'hCAFE_F00D, 32'hCAFE_F00D}) begin
            bad++; $display("FAIL mt_both got=%h exp=%h", {hi, lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_div_zero();
        int oc, of, sc, ec;
        logic to;
        do_div(1'b1, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 2, oc, of, sc, ec, to);
        total++; if (to !== 1'b0) begin bad++; $display("FAIL dz_timeout got=%b exp=0", to); end
`ifdef DIV_ZERO_BYPASS_EN
        total++; if (oc !== 0) begin bad++; $display("FAIL dz_opn_count got=%0d exp=0", oc); end
        total++; if (sc !== 1) begin bad++; $display("FAIL dz_stall_cycles got=%0d exp=1", sc); end
`else
        total++; if (oc !== 1) begin bad++; $display("FAIL dz_opn_count got=%0d exp=1", oc); end
        total++; if (sc !== 4) begin bad++; $display("FAIL dz_stall_cycles got=%0d exp=4", sc); end
`endif
        total++; if (hi !== 32'd5) begin bad++; $display("FAIL dz_hi got=%h exp=%h", hi, 32'd5); end
        total++; if (lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz_lo got=%h exp=%h", lo, 32'hFFFF_FFFF); end
        @(posedge clk); #1;
        ex_div_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        test_reset();
        test_div_basic();
        test_div_signs();
        test_flush_wait();
        test_done_hold();
        test_mt();
        test_div_zero();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
